// File: rtl/power_ctrl_pkg.sv
// Shared definitions for the power-shut-off sequencer: state encodings and
// default build parameters.
package power_ctrl_pkg;

   localparam int NUM_SW_DEF = 2;
   localparam int STAB_W_DEF = 5;
   localparam int ACK_TO_DEF = 64;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_CLK_OFF   = 4'd1,
      ST_WAIT1     = 4'd2,
      ST_ISOLATE   = 4'd3,
      ST_SAVE      = 4'd4,
      ST_RST_ON    = 4'd5,
      ST_PWR_DN    = 4'd6,
      ST_OFF       = 4'd7,
      ST_PWR_UP    = 4'd8,
      ST_WAIT_STAB = 4'd9,
      ST_RESTORE   = 4'd10,
      ST_WAIT2     = 4'd11,
      ST_DE_ISO    = 4'd12,
      ST_CLK_ON    = 4'd13,
      ST_RST_CLR   = 4'd14
   } pso_state_e;

endpackage

// File: rtl/power_ctrl_dly_cnt.sv
// Loadable down-counter with a done flag; shared by the stabilisation wait
// and the switch-acknowledge timeout, which never overlap.
module power_ctrl_dly_cnt #(
   parameter int W = 6
) (
   input  logic         pclk,
   input  logic         nprst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_done
);

   logic [W-1:0] r_cnt;

   // Counts down to zero and holds there until the next load.
   always_ff @(posedge pclk or negedge nprst) begin
      if (!nprst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_done = (r_cnt == '0);

endmodule

// File: rtl/power_ctrl_seq.sv
// PSO sequencer for one switchable power domain: clock gating, isolation,
// retention save/restore, non-SRPG reset and a sequential power-switch chain.
module power_ctrl_seq
   import power_ctrl_pkg::*;
#(
   parameter int NUM_SW = NUM_SW_DEF,
   parameter int STAB_W = STAB_W_DEF,
   parameter int ACK_TO = ACK_TO_DEF
) (
   input  logic              pclk,
   input  logic              nprst,
   input  logic              pso_req,
   input  logic [STAB_W-1:0] stab_cycles,
   input  logic [NUM_SW-1:0] pwr_ack,
   output logic              gate_clk,
   output logic              isolate,
   output logic              save_edge,
   output logic              restore_edge,
   output logic              rstn_non_srpg,
   output logic [NUM_SW-1:0] pwr_on,
   output logic              set_status,
   output logic              clr_status,
   output logic              abort,
   output logic              ack_err,
   output logic [3:0]        state
);

   localparam int ACK_TW = $clog2(ACK_TO);
   localparam int CNT_W  = (STAB_W > ACK_TW) ? STAB_W : ACK_TW;
   localparam int KW     = (NUM_SW > 1) ? $clog2(NUM_SW) : 1;
   localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(ACK_TO - 1);
   localparam logic [KW-1:0]    LAST_K  = KW'(NUM_SW - 1);

   pso_state_e        r_state;
   logic [KW-1:0]     r_k;
   logic              r_gate;
   logic              r_iso;
   logic              r_save;
   logic              r_restore;
   logic              r_rstn;
   logic [NUM_SW-1:0] r_pwr;
   logic              r_set;
   logic              r_clr;
   logic              r_abort;
   logic              r_ack_err;

   pso_state_e        w_next;
   logic [KW-1:0]     w_k_nxt;
   logic              w_load;
   logic [CNT_W-1:0]  w_load_val;
   logic [CNT_W-1:0]  w_stab_load;
   logic [STAB_W-1:0] w_stab_m1;
   logic              w_done;
   logic              w_timeout;
   logic              w_abort;
   logic [NUM_SW-1:0] w_pwr_nxt;

   // A zero stabilisation request still spends one cycle in WAIT_STAB.
   assign w_stab_m1   = stab_cycles - STAB_W'(1);
   assign w_stab_load = (stab_cycles == '0) ? '0 : CNT_W'(w_stab_m1);

   power_ctrl_dly_cnt #(.W(CNT_W)) u_dly_cnt (
      .pclk       (pclk),
      .nprst      (nprst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_done     (w_done)
   );

   always_comb begin
      w_next     = r_state;
      w_k_nxt    = r_k;
      w_load     = 1'b0;
      w_load_val = TO_LOAD;
      w_timeout  = 1'b0;
      w_abort    = 1'b0;
      case (r_state)
         ST_IDLE:      if (pso_req) w_next = ST_CLK_OFF;
         ST_CLK_OFF,
         ST_WAIT1: begin
            if (!pso_req) begin
               w_next  = ST_CLK_ON;
               w_abort = 1'b1;
            end else begin
               w_next = (r_state == ST_CLK_OFF) ? ST_WAIT1 : ST_ISOLATE;
            end
         end
         ST_ISOLATE:   w_next = ST_SAVE;
         ST_SAVE:      w_next = ST_RST_ON;
         ST_RST_ON: begin
            w_next = ST_PWR_DN;
            w_load = 1'b1;
         end
         ST_PWR_DN: begin
            if (pwr_ack == '0) begin
               w_next = ST_OFF;
            end else if (w_done) begin
               w_next    = ST_OFF;
               w_timeout = 1'b1;
            end
         end
         ST_OFF: begin
            if (!pso_req) begin
               w_next  = ST_PWR_UP;
               w_k_nxt = '0;
               w_load  = 1'b1;
            end
         end
         // Timeout reload on every advance gives each switch a full window.
         ST_PWR_UP: begin
            if (pwr_ack[r_k] || w_done) begin
               w_timeout = !pwr_ack[r_k];
               w_load    = 1'b1;
               if (r_k == LAST_K) begin
                  w_next     = ST_WAIT_STAB;
                  w_load_val = w_stab_load;
               end else begin
                  w_k_nxt = r_k + KW'(1);
               end
            end
         end
         ST_WAIT_STAB: if (w_done) w_next = ST_RESTORE;
         ST_RESTORE:   w_next = ST_WAIT2;
         ST_WAIT2:     w_next = ST_DE_ISO;
         ST_DE_ISO:    w_next = ST_CLK_ON;
         ST_CLK_ON:    w_next = ST_RST_CLR;
         ST_RST_CLR:   w_next = ST_IDLE;
         default:      w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_pwr_nxt = '1;
      if (w_next == ST_PWR_DN || w_next == ST_OFF) begin
         w_pwr_nxt = '0;
      end else if (w_next == ST_PWR_UP) begin
         for (int i = 0; i < NUM_SW; i++) begin
            w_pwr_nxt[i] = (i <= int'(w_k_nxt));
         end
      end
   end

   // Outputs are decoded from the next state so they move with the state.
   always_ff @(posedge pclk or negedge nprst) begin
      if (!nprst) begin
         r_state   <= ST_IDLE;
         r_k       <= '0;
         r_gate    <= 1'b0;
         r_iso     <= 1'b0;
         r_save    <= 1'b0;
         r_restore <= 1'b0;
         r_rstn    <= 1'b1;
         r_pwr     <= '1;
         r_set     <= 1'b0;
         r_clr     <= 1'b0;
         r_abort   <= 1'b0;
         r_ack_err <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_k       <= w_k_nxt;
         r_gate    <= !(w_next inside {ST_IDLE, ST_CLK_ON, ST_RST_CLR});
         r_iso     <= w_next inside {ST_ISOLATE, ST_SAVE, ST_RST_ON, ST_PWR_DN,
                                     ST_OFF, ST_PWR_UP, ST_WAIT_STAB,
                                     ST_RESTORE, ST_WAIT2};
         r_save    <= (w_next == ST_SAVE);
         r_restore <= (w_next == ST_RESTORE);
         r_rstn    <= !(w_next inside {ST_RST_ON, ST_PWR_DN, ST_OFF, ST_PWR_UP,
                                       ST_WAIT_STAB, ST_RESTORE, ST_WAIT2,
                                       ST_DE_ISO});
         r_pwr     <= w_pwr_nxt;
         r_set     <= (w_next == ST_CLK_OFF);
         r_clr     <= (w_next == ST_RST_CLR);
         r_abort   <= w_abort;
         if (w_next == ST_CLK_OFF) begin
            r_ack_err <= 1'b0;
         end else if (w_timeout) begin
            r_ack_err <= 1'b1;
         end
      end
   end

   assign gate_clk      = r_gate;
   assign isolate       = r_iso;
   assign save_edge     = r_save;
   assign restore_edge  = r_restore;
   assign rstn_non_srpg = r_rstn & nprst;
   assign pwr_on        = r_pwr;
   assign set_status    = r_set;
   assign clr_status    = r_clr;
   assign abort         = r_abort;
   assign ack_err       = r_ack_err;
   assign state         = r_state;

endmodule

// File: tb/tb_power_ctrl_seq.sv
// Directed bench for power_ctrl_seq: cycle-by-cycle vector table for entry,
// exit and abort, plus hand sequences for timeout, stabilisation and reset.
module tb_power_ctrl_seq;

   logic       pclk = 1'b0;
   logic       nprst = 1'b0;
   logic       pso_req = 1'b0;
   logic [4:0] stab_cycles = 5'd4;
   logic [1:0] pwr_ack = 2'b00;
   logic       gate_clk, isolate, save_edge, restore_edge, rstn_non_srpg;
   logic [1:0] pwr_on;
   logic       set_status, clr_status, abort, ack_err;
   logic [3:0] state;

   logic [1:0] ackMask = 2'b11;
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;

   typedef struct {
      logic       req;
      logic [3:0] st;
      logic       gate, iso, save, rest, rstn;
      logic [1:0] pwr;
      logic       set, clr, abt, err;
   } vec_t;

   vec_t vecs[$];

   power_ctrl_seq #(.NUM_SW(2), .STAB_W(5), .ACK_TO(64)) dut (
      .pclk          (pclk),
      .nprst         (nprst),
      .pso_req       (pso_req),
      .stab_cycles   (stab_cycles),
      .pwr_ack       (pwr_ack),
      .gate_clk      (gate_clk),
      .isolate       (isolate),
      .save_edge     (save_edge),
      .restore_edge  (restore_edge),
      .rstn_non_srpg (rstn_non_srpg),
      .pwr_on        (pwr_on),
      .set_status    (set_status),
      .clr_status    (clr_status),
      .abort         (abort),
      .ack_err       (ack_err),
      .state         (state)
   );

   always #5 pclk = ~pclk;

   // Switches acknowledge one cycle after their enable; ackMask models stuck switches.
   always @(posedge pclk) pwr_ack <= pwr_on & ackMask;

   function automatic vec_t mk(logic req, logic [3:0] st, logic gate, logic iso,
                               logic save, logic rest, logic rstn, logic [1:0] pwr,
                               logic set, logic clr, logic abt, logic err);
      vec_t v;
      v.req = req; v.st = st; v.gate = gate; v.iso = iso; v.save = save;
      v.rest = rest; v.rstn = rstn; v.pwr = pwr; v.set = set; v.clr = clr;
      v.abt = abt; v.err = err;
      return v;
   endfunction

   task automatic tick();
      @(posedge pclk);
      #1;
      cyc++;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      pso_req = v.req;
      tick();
      checkOutput($sformatf("vec%0d.state", idx), 32'(state), 32'(v.st));
      checkOutput($sformatf("vec%0d.gate", idx), 32'(gate_clk), 32'(v.gate));
      checkOutput($sformatf("vec%0d.iso", idx), 32'(isolate), 32'(v.iso));
      checkOutput($sformatf("vec%0d.save", idx), 32'(save_edge), 32'(v.save));
      checkOutput($sformatf("vec%0d.restore", idx), 32'(restore_edge), 32'(v.rest));
      checkOutput($sformatf("vec%0d.rstn", idx), 32'(rstn_non_srpg), 32'(v.rstn));
      checkOutput($sformatf("vec%0d.pwr_on", idx), 32'(pwr_on), 32'(v.pwr));
      checkOutput($sformatf("vec%0d.set", idx), 32'(set_status), 32'(v.set));
      checkOutput($sformatf("vec%0d.clr", idx), 32'(clr_status), 32'(v.clr));
      checkOutput($sformatf("vec%0d.abort", idx), 32'(abort), 32'(v.abt));
      checkOutput($sformatf("vec%0d.ack_err", idx), 32'(ack_err), 32'(v.err));
   endtask

   task automatic waitState(input logic [3:0] target, input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         if (state == target) break;
         tick();
      end
      checkOutput(name, 32'(state), 32'(target));
   endtask

   task automatic enterOff(input string name);
      pso_req = 1'b1;
      waitState(4'd7, 40, name);
   endtask

   task automatic runExit(input string name, input int expStab);
      int stabCnt = 0;
      int clrCnt = 0;
      pso_req = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (state == 4'd9) stabCnt++;
         if (clr_status) clrCnt++;
         if (state == 4'd0) break;
      end
      checkOutput({name, ".state"}, 32'(state), 32'd0);
      checkOutput({name, ".stabLen"}, 32'(stabCnt), 32'(expStab));
      checkOutput({name, ".clrPulses"}, 32'(clrCnt), 32'd1);
      checkOutput({name, ".ack_err"}, 32'(ack_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      int rise;
      int errAt;
      int clrCnt;

      // Full entry/exit with stab_cycles=4, then two abort variants.
      vecs.push_back(mk(1, 4'd1,  1,0,0,0,1, 2'b11, 1,0,0,0));
      vecs.push_back(mk(1, 4'd2,  1,0,0,0,1, 2'b11, 0,0,0,0));
      vecs.push_back(mk(1, 4'd3,  1,1,0,0,1, 2'b11, 0,0,0,0));
      vecs.push_back(mk(1, 4'd4,  1,1,1,0,1, 2'b11, 0,0,0,0));
      vecs.push_back(mk(1, 4'd5,  1,1,0,0,0, 2'b11, 0,0,0,0));
      vecs.push_back(mk(1, 4'd6,  1,1,0,0,0, 2'b00, 0,0,0,0));
      vecs.push_back(mk(1, 4'd6,  1,1,0,0,0, 2'b00, 0,0,0,0));
      vecs.push_back(mk(1, 4'd7,  1,1,0,0,0, 2'b00, 0,0,0,0));
      vecs.push_back(mk(1, 4'd7,  1,1,0,0,0, 2'b00, 0,0,0,0));
      vecs.push_back(mk(0, 4'd8,  1,1,0,0,0, 2'b01, 0,0,0,0));
      vecs.push_back(mk(0, 4'd8,  1,1,0,0,0, 2'b01, 0,0,0,0));
      vecs.push_back(mk(0, 4'd8,  1,1,0,0,0, 2'b11, 0,0,0,0));
      vecs.push_back(mk(0, 4'd8,  1,1,0,0,0, 2'b11, 0,0,0,0));
      vecs.push_back(mk(0, 4'd9,  1,1,0,0,0, 2'b11, 0,0,0,0));
      vecs.push_back(mk(0, 4'd9,  1,1,0,0,0, 2'b11, 0,0,0,0));
      vecs.push_back(mk(0, 4'd9,  1,1,0,0,0, 2'b11, 0,0,0,0));
      vecs.push_back(mk(0, 4'd9,  1,1,0,0,0, 2'b11, 0,0,0,0));
      vecs.push_back(mk(0, 4'd10, 1,1,0,1,0, 2'b11, 0,0,0,0));
      vecs.push_back(mk(0, 4'd11, 1,1,0,0,0, 2'b11, 0,0,0,0));
      vecs.push_back(mk(0, 4'd12, 1,0,0,0,0, 2'b11, 0,0,0,0));
      vecs.push_back(mk(0, 4'd13, 0,0,0,0,1, 2'b11, 0,0,0,0));
      vecs.push_back(mk(0, 4'd14, 0,0,0,0,1, 2'b11, 0,1,0,0));
      vecs.push_back(mk(0, 4'd0,  0,0,0,0,1, 2'b11, 0,0,0,0));
      vecs.push_back(mk(1, 4'd1,  1,0,0,0,1, 2'b11, 1,0,0,0));
      vecs.push_back(mk(1, 4'd2,  1,0,0,0,1, 2'b11, 0,0,0,0));
      vecs.push_back(mk(0, 4'd13, 0,0,0,0,1, 2'b11, 0,0,1,0));
      vecs.push_back(mk(0, 4'd14, 0,0,0,0,1, 2'b11, 0,1,0,0));
      vecs.push_back(mk(0, 4'd0,  0,0,0,0,1, 2'b11, 0,0,0,0));
      vecs.push_back(mk(1, 4'd1,  1,0,0,0,1, 2'b11, 1,0,0,0));
      vecs.push_back(mk(0, 4'd13, 0,0,0,0,1, 2'b11, 0,0,1,0));
      vecs.push_back(mk(0, 4'd14, 0,0,0,0,1, 2'b11, 0,1,0,0));
      vecs.push_back(mk(0, 4'd0,  0,0,0,0,1, 2'b11, 0,0,0,0));

      tick();
      tick();
      checkOutput("reset.state", 32'(state), 32'd0);
      checkOutput("reset.gate", 32'(gate_clk), 32'd0);
      checkOutput("reset.iso", 32'(isolate), 32'd0);
      checkOutput("reset.rstn", 32'(rstn_non_srpg), 32'd0);
      checkOutput("reset.pwr_on", 32'(pwr_on), 32'd3);
      checkOutput("reset.pulses", 32'({save_edge, restore_edge, set_status, clr_status, abort}), 32'd0);
      checkOutput("reset.ack_err", 32'(ack_err), 32'd0);
      nprst = 1'b1;
      tick();
      checkOutput("idle.rstn", 32'(rstn_non_srpg), 32'd1);
      tick();
      tick();

      foreach (vecs[i]) applyStimulus(vecs[i], i);

      // Switch 1 never acknowledges: timeout must flag 64 cycles after its enable.
      ackMask = 2'b01;
      enterOff("to.off");
      pso_req = 1'b0;
      rise = -1;
      errAt = -1;
      clrCnt = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (state == 4'd8 && pwr_on[1] && rise < 0) rise = cyc;
         if (ack_err && errAt < 0) errAt = cyc;
         if (clr_status) clrCnt++;
         if (state == 4'd0) break;
      end
      checkOutput("to.state", 32'(state), 32'd0);
      checkOutput("to.delay", 32'(errAt - rise), 32'd64);
      checkOutput("to.clrPulses", 32'(clrCnt), 32'd1);
      ackMask = 2'b11;
      tick();
      tick();
      checkOutput("to.errHeld", 32'(ack_err), 32'd1);
      pso_req = 1'b1;
      tick();
      checkOutput("to.clkOff", 32'(state), 32'd1);
      checkOutput("to.errCleared", 32'(ack_err), 32'd0);
      pso_req = 1'b0;
      waitState(4'd0, 10, "to.abortIdle");

      stab_cycles = 5'd0;
      enterOff("stab0.off");
      runExit("stab0", 1);
      stab_cycles = 5'd31;
      enterOff("stab31.off");
      runExit("stab31", 31);

      // Asynchronous reset while powered off, with the request still held.
      stab_cycles = 5'd4;
      enterOff("rst.off");
      #2;
      nprst = 1'b0;
      #1;
      checkOutput("rst.pwr_on", 32'(pwr_on), 32'd3);
      checkOutput("rst.iso", 32'(isolate), 32'd0);
      checkOutput("rst.gate", 32'(gate_clk), 32'd0);
      checkOutput("rst.state", 32'(state), 32'd0);
      checkOutput("rst.rstn", 32'(rstn_non_srpg), 32'd0);
      tick();
      checkOutput("rst.hold", 32'(state), 32'd0);
      nprst = 1'b1;
      tick();
      checkOutput("rst.reentry", 32'(state), 32'd1);
      checkOutput("rst.set", 32'(set_status), 32'd1);
      pso_req = 1'b0;
      waitState(4'd0, 10, "rst.final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
